random_delay_timer: RTL and testbench

RANDOM_DELAY_TIMER -- requirements
Module: random_delay_timer

---
 rtl/standoff_pkg.sv | 23 ++
 rtl/tick_gen.sv | 30 +++
 rtl/random_delay_timer.sv | 108 ++++++++++
 tb/tb_random_delay_timer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/standoff_pkg.sv
// Shared state encoding and width helpers for the random delay timer.
package standoff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WAIT    = 3'd3,
    ST_FIRE    = 3'd4
  } state_e;

  // Bits needed to count 0..span-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned span);
    return (span <= 1) ? 1 : $clog2(span);
  endfunction

  // Bits needed to hold min_ticks + 2^rand_bits - 1 without wrap.
  function automatic int unsigned tick_cnt_w(input int unsigned min_ticks,
                                             input int unsigned rand_bits);
    return cnt_w(min_ticks + (1 << rand_bits));
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
module tick_gen
  import standoff_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PRE_W = cnt_w(TICK_DIV);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/random_delay_timer.sv
// Seeds an LFSR, collects RAND_BITS random bits, waits (MIN_TICKS + value)
// ticks, then pulses draw for one cycle.
module random_delay_timer
  import standoff_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned MIN_TICKS = 1000,
  parameter int unsigned RAND_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 rnd_bit,
  output logic                 lfsr_load,
  output logic                 busy,
  output logic                 draw,
  output logic [RAND_BITS-1:0] rnd_value
);

  localparam int unsigned BIT_W  = cnt_w(RAND_BITS);
  localparam int unsigned TCNT_W = tick_cnt_w(MIN_TICKS, RAND_BITS);

  state_e               state_q;
  state_e               state_d;
  logic [BIT_W-1:0]     bit_cnt;
  logic [TCNT_W-1:0]    tick_cnt;
  logic [RAND_BITS-1:0] rnd_shift;
  logic                 tick;
  logic                 tick_clear;
  logic                 last_bit;
  logic                 last_tick;
  logic                 lfsr_load_d;
  logic                 busy_d;
  logic                 draw_d;

  assign tick_clear = (state_q != ST_WAIT);
  assign rnd_shift  = (rnd_value << 1) | RAND_BITS'(rnd_bit);
  assign last_bit   = (bit_cnt == BIT_W'(RAND_BITS - 1));
  assign last_tick  = tick && (tick_cnt == TCNT_W'(1));

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  // Next state and registered-output decode; abort beats start in IDLE.
  always_comb begin
    state_d     = state_q;
    lfsr_load_d = 1'b0;
    busy_d      = 1'b0;
    draw_d      = 1'b0;
    case (state_q)
      ST_IDLE:    if (start && !abort) state_d = ST_SEED;
      ST_SEED:    state_d = abort ? ST_IDLE : ST_COLLECT;
      ST_COLLECT: begin
        if (abort)         state_d = ST_IDLE;
        else if (last_bit) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort)          state_d = ST_IDLE;
        else if (last_tick) state_d = ST_FIRE;
      end
      ST_FIRE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    lfsr_load_d = (state_d == ST_SEED);
    busy_d      = (state_d != ST_IDLE);
    draw_d      = (state_d == ST_FIRE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lfsr_load <= 1'b0;
      busy      <= 1'b0;
      draw      <= 1'b0;
      bit_cnt   <= '0;
      tick_cnt  <= '0;
      rnd_value <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_load <= lfsr_load_d;
      busy      <= busy_d;
      draw      <= draw_d;

      // An aborted collect keeps whatever bits were already shifted in.
      if (state_q == ST_COLLECT && !abort) begin
        rnd_value <= rnd_shift;
        bit_cnt   <= bit_cnt + 1'b1;
      end else begin
        bit_cnt   <= '0;
      end

      // Load on WAIT entry using the value that includes the final bit.
      if (state_d != ST_WAIT) begin
        tick_cnt <= '0;
      end else if (state_q != ST_WAIT) begin
        tick_cnt <= TCNT_W'(MIN_TICKS) + TCNT_W'(rnd_shift);
      end else if (tick) begin
        tick_cnt <= tick_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_random_delay_timer.sv
// Self-checking bench for random_delay_timer: vector table plus scoreboard.
module tb_random_delay_timer;

  logic       clk = 1'b0;
  logic       reset, start, abort, rnd_bit;
  logic       lfsr_load, busy, draw;
  logic [3:0] rnd_value;
  logic       mx_start, mx_abort, mx_rnd_bit;
  logic       mx_lfsr_load, mx_busy, mx_draw;
  logic [3:0] mx_rnd_value;

  always #5 clk = ~clk;

  random_delay_timer #(.TICK_DIV(4), .MIN_TICKS(2), .RAND_BITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .rnd_bit(rnd_bit),
    .lfsr_load(lfsr_load), .busy(busy), .draw(draw), .rnd_value(rnd_value)
  );

  random_delay_timer #(.TICK_DIV(1), .MIN_TICKS(2), .RAND_BITS(4)) dut_max (
    .clk(clk), .reset(reset), .start(mx_start), .abort(mx_abort), .rnd_bit(mx_rnd_bit),
    .lfsr_load(mx_lfsr_load), .busy(mx_busy), .draw(mx_draw), .rnd_value(mx_rnd_value)
  );

  typedef struct {
    logic [3:0]  bits;
    int          abort_at;   // WAIT cycle to abort at, -1 for none
    bit          mid_start;
    int unsigned exp_wait;
    logic [3:0]  exp_rnd;
  } vec_t;

  typedef struct {
    logic [3:0]  rnd;
    int unsigned busy_len;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   busy_len = 0;
  int   load_cnt = 0;
  logic prev_draw = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every draw must match the oldest expected round.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && busy) begin
      busy_len++;
      if (lfsr_load) load_cnt++;
    end
    if (reset && draw) begin
      chk("draw_width", 32'(prev_draw), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_draw", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("draw_rnd", 32'(rnd_value), 32'(e.rnd));
        chk("busy_len", 32'(busy_len), e.busy_len);
        chk("load_cycles", 32'(load_cnt), 32'd1);
      end
    end
    if (!busy || !reset) begin
      busy_len = 0;
      load_cnt = 0;
    end
    prev_draw = draw;
  end

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    start = 1'b1;
    if (v.abort_at < 0) sb_q.push_back('{v.exp_rnd, v.exp_wait + 6});
    @(negedge clk);
    start = 1'b0;
    chk("seed_load", 32'(lfsr_load), 32'd1);
    chk("seed_busy", 32'(busy), 32'd1);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      rnd_bit = v.bits[i];
    end
    @(negedge clk);
    chk("wait_rnd", 32'(rnd_value), 32'(v.exp_rnd));
    chk("wait_load", 32'(lfsr_load), 32'd0);
    if (v.abort_at >= 0) begin
      repeat (v.abort_at) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_draw", 32'(draw), 32'd0);
      chk("abort_rnd", 32'(rnd_value), 32'(v.exp_rnd));
      repeat (v.exp_wait) @(negedge clk);
      chk("abort_idle", 32'(busy), 32'd0);
    end else begin
      if (v.mid_start) begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      n = 0;
      while (busy && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("round_done", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("idle_after", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   n;
    vecs[0] = '{4'b1011, -1, 1'b0, 52, 4'b1011};
    vecs[1] = '{4'b0000, -1, 1'b0,  8, 4'b0000};
    vecs[2] = '{4'b1011, 10, 1'b0, 52, 4'b1011};
    vecs[3] = '{4'b0101, -1, 1'b0, 28, 4'b0101};
    vecs[4] = '{4'b1111, -1, 1'b1, 68, 4'b1111};
    vecs[5] = '{4'b1000, -1, 1'b0, 40, 4'b1000};

    reset = 1'b0; start = 1'b0; abort = 1'b0; rnd_bit = 1'b0;
    mx_start = 1'b0; mx_abort = 1'b0; mx_rnd_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_draw", 32'(draw), 32'd0);
    chk("reset_load", 32'(lfsr_load), 32'd0);
    chk("reset_rnd", 32'(rnd_value), 32'd0);
    chk("reset_mx_busy", 32'(mx_busy), 32'd0);
    reset = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Start and abort together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_load", 32'(lfsr_load), 32'd0);
    repeat (2) @(negedge clk);
    chk("both_idle", 32'(busy), 32'd0);

    // Reset pulse during the third collect cycle.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rnd_bit = 1'b1;
    @(negedge clk);
    rnd_bit = 1'b1;
    @(negedge clk);
    chk("pre_reset_rnd", 32'(rnd_value), 32'd3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_rnd", 32'(rnd_value), 32'd0);
    chk("midreset_load", 32'(lfsr_load), 32'd0);
    chk("midreset_draw", 32'(draw), 32'd0);
    repeat (3) @(negedge clk);
    chk("midreset_idle", 32'(busy), 32'd0);

    // Largest value with a one-cycle tick: WAIT of 17 cycles.
    @(negedge clk);
    mx_start = 1'b1;
    @(negedge clk);
    mx_start = 1'b0;
    chk("mx_seed_load", 32'(mx_lfsr_load), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mx_rnd_bit = 1'b1;
    end
    @(negedge clk);
    chk("mx_rnd", 32'(mx_rnd_value), 32'd15);
    n = 0;
    while (!mx_draw && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mx_wait", 32'(n), 32'd17);
    chk("mx_draw", 32'(mx_draw), 32'd1);
    @(negedge clk);
    chk("mx_done", 32'(mx_busy), 32'd0);
    chk("mx_draw_low", 32'(mx_draw), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
